// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: synchronises and debounces pll_lock, gates sys_rst_n, counts lock losses.
// Defining PLL_SUPERVISOR_RETRY_EN adds the lock-timeout PLL reset pulse and the retry counter.
module pll_lock_supervisor #(
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 125000,
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOSS_CNT_W          = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pll_lock,
    output logic                  pll_rst,
    output logic                  sys_rst_n,
    output logic                  locked,
    output logic [LOSS_CNT_W-1:0] loss_cnt,
    output logic [LOSS_CNT_W-1:0] retry_cnt,
    output logic [1:0]            state_dbg
);
    localparam int MAX_NT  = (LOCK_STABLE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                             LOCK_STABLE_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int MAX_ALL = (MAX_NT > PLL_RST_CYCLES) ? MAX_NT : PLL_RST_CYCLES;
    localparam int CNT_W   = $clog2(MAX_ALL) + 1;
    localparam logic [CNT_W-1:0] N_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        RESET_PLL = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    logic [1:0]            sync_q;
    logic                  lock_s;
    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [LOSS_CNT_W-1:0] loss_q, loss_d;
    logic                  run_q, run_d;

    assign lock_s = sync_q[1];

`ifdef PLL_SUPERVISOR_RETRY_EN
    localparam logic [CNT_W-1:0] T_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] R_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    logic [LOSS_CNT_W-1:0] retry_q, retry_d;
    logic                  pll_rst_q, pll_rst_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        loss_d  = loss_q;
`ifdef PLL_SUPERVISOR_RETRY_EN
        retry_d = retry_q;
`endif
        case (state_q)
            WAIT_LOCK: begin
                // Lock takes priority over an expiring timeout in the same cycle.
                if (lock_s) begin
                    state_d = STABLE;
`ifdef PLL_SUPERVISOR_RETRY_EN
                end else if (cnt_q == T_LAST) begin
                    state_d = RESET_PLL;
                    if (retry_q != '1) retry_d = retry_q + 1'b1;
                end
`else
                end else if (cnt_q == '1) begin
                    cnt_d = cnt_q;
                end
`endif
            end
`ifdef PLL_SUPERVISOR_RETRY_EN
            RESET_PLL: begin
                if (cnt_q == R_LAST) state_d = WAIT_LOCK;
            end
`endif
            STABLE: begin
                if (!lock_s) state_d = WAIT_LOCK;
                else if (cnt_q == N_LAST) state_d = RUN;
            end
            RUN: begin
                cnt_d = cnt_q;
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    if (loss_q != '1) loss_d = loss_q + 1'b1;
                end
            end
            default: state_d = WAIT_LOCK;
        endcase
        if (state_d != state_q) cnt_d = '0;
        run_d = (state_d == RUN);
`ifdef PLL_SUPERVISOR_RETRY_EN
        pll_rst_d = (state_d == RESET_PLL);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
            loss_q  <= '0;
            run_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], pll_lock};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            loss_q  <= loss_d;
            run_q   <= run_d;
        end
    end

`ifdef PLL_SUPERVISOR_RETRY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retry_q   <= '0;
            pll_rst_q <= 1'b0;
        end else begin
            retry_q   <= retry_d;
            pll_rst_q <= pll_rst_d;
        end
    end

    assign pll_rst   = pll_rst_q;
    assign retry_cnt = retry_q;
`else
    assign pll_rst   = 1'b0;
    assign retry_cnt = '0;
`endif

    assign sys_rst_n = run_q;
    assign locked    = run_q;
    assign loss_cnt  = loss_q;
    assign state_dbg = state_q;
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor (N=8, T=32, R=4, 2-bit counters).
// Expectations follow PLL_SUPERVISOR_RETRY_EN as seen by this compile.
module tb_pll_lock_supervisor;
    localparam int N  = 8;
    localparam int T  = 32;
    localparam int R  = 4;
    localparam int LW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pll_lock = 1'b0;
    logic          pll_rst;
    logic          sys_rst_n;
    logic          locked;
    logic [LW-1:0] loss_cnt;
    logic [LW-1:0] retry_cnt;
    logic [1:0]    state_dbg;

    int n_tests = 0;
    int n_fail  = 0;

    pll_lock_supervisor #(
        .LOCK_STABLE_CYCLES (N),
        .LOCK_TIMEOUT_CYCLES(T),
        .PLL_RST_CYCLES     (R),
        .LOSS_CNT_W         (LW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pll_lock (pll_lock),
        .pll_rst  (pll_rst),
        .sys_rst_n(sys_rst_n),
        .locked   (locked),
        .loss_cnt (loss_cnt),
        .retry_cnt(retry_cnt),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Returns 1 ns after a rising edge, so outputs have settled and inputs are away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        pll_lock = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        pll_lock = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({pll_rst, sys_rst_n, locked} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_outputs got pll_rst/sys_rst_n/locked=%b exp 000", {pll_rst, sys_rst_n, locked});
        end
        n_tests++;
        if ({loss_cnt, retry_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_counters got loss=%0d retry=%0d exp 0/0", loss_cnt, retry_cnt);
        end
    endtask

    task automatic test_clean_lock();
        do_reset();
        repeat (5) step();
        pll_lock = 1'b1;
        for (int e = 0; e <= 12; e++) begin
            logic exp_l;
            step();
            exp_l = (e >= N + 2);
            n_tests++;
            if ({locked, sys_rst_n} !== {exp_l, exp_l}) begin
                n_fail++;
                $display("FAIL clean_lock e=%0d got locked=%b sys_rst_n=%b exp %b", e, locked, sys_rst_n, exp_l);
            end
            n_tests++;
            if (pll_rst !== 1'b0 || loss_cnt !== '0) begin
                n_fail++;
                $display("FAIL clean_lock_aux e=%0d got pll_rst=%b loss=%0d exp 0/0", e, pll_rst, loss_cnt);
            end
        end
    endtask

    task automatic test_glitch();
        do_reset();
        pll_lock = 1'b1;
        for (int e = 0; e <= 18; e++) begin
            logic exp_l;
            step();
            if (e == 5) pll_lock = 1'b0;
            if (e == 6) pll_lock = 1'b1;
            // High is re-sampled at edge 7, so release lands at 7 + N + 2.
            exp_l = (e >= 7 + N + 2);
            n_tests++;
            if ({locked, sys_rst_n} !== {exp_l, exp_l} || loss_cnt !== '0) begin
                n_fail++;
                $display("FAIL glitch e=%0d got locked=%b sys_rst_n=%b loss=%0d exp %b/0", e, locked, sys_rst_n, loss_cnt, exp_l);
            end
        end
    endtask

    task automatic test_loss_run();
        pll_lock = 1'b0;
        for (int f = 0; f <= 14; f++) begin
            logic exp_l;
            int   exp_loss;
            step();
            if (f == 2) pll_lock = 1'b1;
            exp_l    = (f < 2) || (f >= 3 + N + 2);
            exp_loss = (f >= 2) ? 1 : 0;
            n_tests++;
            if ({locked, sys_rst_n} !== {exp_l, exp_l} || loss_cnt !== LW'(exp_loss)) begin
                n_fail++;
                $display("FAIL loss_run f=%0d got locked=%b sys_rst_n=%b loss=%0d exp %b/%0d", f, locked, sys_rst_n, loss_cnt, exp_l, exp_loss);
            end
        end
    endtask

    task automatic test_saturation();
        for (int k = 2; k <= 5; k++) begin
            int exp_loss;
            exp_loss = (k > 3) ? 3 : k;
            pll_lock = 1'b0;
            step();
            step();
            pll_lock = 1'b1;
            step();
            n_tests++;
            if (locked !== 1'b0 || loss_cnt !== LW'(exp_loss)) begin
                n_fail++;
                $display("FAIL sat_drop k=%0d got locked=%b loss=%0d exp 0/%0d", k, locked, loss_cnt, exp_loss);
            end
            repeat (N + 1) step();
            n_tests++;
            if (locked !== 1'b0) begin
                n_fail++;
                $display("FAIL sat_early k=%0d got locked=%b exp 0", k, locked);
            end
            step();
            n_tests++;
            if (locked !== 1'b1) begin
                n_fail++;
                $display("FAIL sat_relock k=%0d got locked=%b exp 1", k, locked);
            end
        end
        repeat (5) step();
        n_tests++;
        if (loss_cnt !== LW'(3)) begin
            n_fail++;
            $display("FAIL sat_hold got loss=%0d exp 3", loss_cnt);
        end
    endtask

    task automatic test_async_reset();
        step();
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({locked, sys_rst_n, pll_rst} !== 3'b000 || loss_cnt !== '0) begin
            n_fail++;
            $display("FAIL async_reset got locked=%b sys_rst_n=%b pll_rst=%b loss=%0d exp 0/0/0/0", locked, sys_rst_n, pll_rst, loss_cnt);
        end
        #1 rst_n = 1'b1;
        for (int e = 0; e <= 10; e++) begin
            logic exp_l;
            step();
            exp_l = (e >= N + 2);
            n_tests++;
            if ({locked, sys_rst_n} !== {exp_l, exp_l} || loss_cnt !== '0) begin
                n_fail++;
                $display("FAIL async_requal e=%0d got locked=%b sys_rst_n=%b loss=%0d exp %b/0", e, locked, sys_rst_n, loss_cnt, exp_l);
            end
        end
    endtask

    task automatic test_no_lock();
        do_reset();
        for (int pass = 0; pass < 2; pass++) begin
            int lim;
            lim = (pass == 0) ? 141 : 40;
            for (int k = 1; k <= lim; k++) begin
                logic exp_rst;
                int   exp_retry;
                step();
                exp_rst   = 1'b0;
                exp_retry = 0;
`ifdef PLL_SUPERVISOR_RETRY_EN
                if (k >= T) begin
                    exp_rst   = ((k - T) % (T + R)) < R;
                    exp_retry = (k - T) / (T + R) + 1;
                    if (exp_retry > 3) exp_retry = 3;
                end
`endif
                n_tests++;
                if (pll_rst !== exp_rst || retry_cnt !== LW'(exp_retry) || locked !== 1'b0) begin
                    n_fail++;
                    $display("FAIL no_lock pass=%0d k=%0d got pll_rst=%b retry=%0d locked=%b exp %b/%0d/0", pass, k, pll_rst, retry_cnt, locked, exp_rst, exp_retry);
                end
            end
            if (pass == 0) begin
                #2 rst_n = 1'b0;
                #1;
                n_tests++;
                if (pll_rst !== 1'b0 || retry_cnt !== '0) begin
                    n_fail++;
                    $display("FAIL no_lock_trunc got pll_rst=%b retry=%0d exp 0/0", pll_rst, retry_cnt);
                end
                #1 rst_n = 1'b1;
            end
        end
    endtask

    // Reference: the supervisor is released once the synchronised lock flag has been
    // seen high on N+1 consecutive edges; lock_s is pll_lock delayed by two edges.
    task automatic test_random();
        logic samp_q[$];
        int   ones_run;
        int   loss_m;
        logic prev_l;
        do_reset();
        samp_q   = '{1'b0, 1'b0};
        ones_run = 0;
        loss_m   = 0;
        prev_l   = 1'b0;
        for (int seg = 0; seg < 14; seg++) begin
            for (int ph = 0; ph < 2; ph++) begin
                logic lvl;
                int   len;
                lvl = (ph == 0);
                len = lvl ? $urandom_range(1, 24) : $urandom_range(1, 20);
                for (int c = 0; c < len; c++) begin
                    logic s;
                    logic exp_l;
                    pll_lock = lvl;
                    step();
                    samp_q.push_back(lvl);
                    s        = samp_q.pop_front();
                    ones_run = s ? ones_run + 1 : 0;
                    exp_l    = (ones_run >= N + 1);
                    if (prev_l && !exp_l && loss_m < 3) loss_m++;
                    prev_l = exp_l;
                    n_tests++;
                    if ({locked, sys_rst_n} !== {exp_l, exp_l} || loss_cnt !== LW'(loss_m) || pll_rst !== 1'b0) begin
                        n_fail++;
                        $display("FAIL random seg=%0d c=%0d got locked=%b sys_rst_n=%b loss=%0d pll_rst=%b exp %b/%0d/0", seg, c, locked, sys_rst_n, loss_cnt, pll_rst, exp_l, loss_m);
                    end
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_clean_lock();
        test_glitch();
        test_loss_run();
        test_saturation();
        test_async_reset();
        test_no_lock();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Lock supervisor and reset generator for the video PLL output stage. It watches the asynchronous `pll_lock` flag from the PLL wrapper and debounces it against a free-running reference clock. It holds the downstream reset until lock has been stable for a programmable time, and counts loss-of-lock events. Optionally, it pulses the PLL reset input when lock never arrives. It sits between the PLL wrapper and all logic clocked by the PLL output clock.

## Interface
- `LOCK_STABLE_CYCLES`, default 1024: consecutive locked cycles (N) required before release; must be ≥ 1.
- `LOCK_TIMEOUT_CYCLES`, default 125000: cycles (T) without lock before a PLL reset; must be ≥ 2. 125000 cycles is 1 ms at 125 MHz.
- `PLL_RST_CYCLES`, default 16: width (R) of the `pll_rst` pulse; must be ≥ 1.
- `LOSS_CNT_W`, default 8: width of the event counters.
- `clk`  in  1  free-running 125 MHz reference clock, same source as the PLL input. The block uses one clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `pll_lock`  in  1  PLL lock flag, asynchronous to `clk`.
- `pll_rst`  out  1  active-high reset to the PLL.
- `sys_rst_n`  out  1  active-low reset for downstream logic; high only in RUN.
- `locked`  out  1  high only in RUN.
- `loss_cnt`  out  LOSS_CNT_W  count of RUN→WAIT_LOCK transitions; saturating.
- `retry_cnt`  out  LOSS_CNT_W  count of PLL reset pulses issued; saturating.

## Operation
- `pll_lock` passes through a 2-FF synchroniser (both flops reset to 0) to produce `lock_s`.
- The block uses a single counter `cnt` of width `$clog2(max(N,T,R))+1`. `cnt` clears on every state transition.
- **WAIT_LOCK** (reset state):
  - `lock_s`=1 → STABLE.
  - Otherwise `cnt` increments. When `cnt`==T-1 → RESET_PLL and `retry_cnt`++.
  - If `lock_s`=1 and `cnt`==T-1 in the same cycle, lock wins and the state goes to STABLE.
- **RESET_PLL**: `pll_rst`=1 for exactly R cycles, then → WAIT_LOCK. `lock_s` is ignored in this state.
- **STABLE**:
  - `lock_s`=0 → WAIT_LOCK. This is a glitch: `loss_cnt` is unchanged.
  - `cnt`==N-1 with `lock_s`=1 → RUN.
  - If `lock_s`=0 and `cnt`==N-1 in the same cycle, the state goes to WAIT_LOCK.
- **RUN**: `lock_s`=0 → WAIT_LOCK and `loss_cnt`++.
- Counters saturate at all-ones and never wrap.
- All outputs are registered and decoded from the next state, so each output changes on the same edge as the state.

## Timing
- Reset values:
  - `pll_rst`=0, `sys_rst_n`=0, `locked`=0.
  - `loss_cnt`=0, `retry_cnt`=0.
  - State WAIT_LOCK, `cnt`=0.
- Assertion of `rst_n` takes effect immediately without a clock edge, including mid-RUN and mid-RESET_PLL. A RESET_PLL pulse in progress is truncated.
- Edge E0 is the first edge that samples `pll_lock`=1:
  - `lock_s`=1 at E1.
  - STABLE at E2.
  - `sys_rst_n`/`locked` rise at E(N+2).
- Loss of lock: the first edge sampling `pll_lock`=0 is E0; `sys_rst_n`/`locked` fall at E2.
- Timeout: RESET_PLL is entered on the T-th edge after WAIT_LOCK entry. With lock absent permanently, `pll_rst` pulses have period T+R.
- After `rst_n` deassertion with no lock, the first `pll_rst` rise occurs at the T-th edge.

## Configuration
- `PLL_SUPERVISOR_RETRY_EN` defined: timeout → RESET_PLL behaviour as specified above.
- Not defined:
  - RESET_PLL is not built.
  - `pll_rst` is tied 0 and `retry_cnt` is tied 0.
  - `cnt` saturates in WAIT_LOCK and the block waits indefinitely for lock.

## Test plan
Bench parameters: N=8, T=32, R=4, LOSS_CNT_W=2. Macro defined unless stated.
- Clean lock: `pll_lock` goes high 5 cycles after reset release and stays high → `sys_rst_n`/`locked` rise exactly 10 edges after the first high sample. `pll_rst` stays 0 and `loss_cnt`=0.
- Glitch in STABLE: drop `pll_lock` for 1 cycle while `cnt`=5 → return to WAIT_LOCK with `sys_rst_n` held 0 and `loss_cnt`=0. Release occurs 10 edges after `pll_lock` is re-sampled high.
- Loss in RUN: drop `pll_lock` for 3 cycles → `sys_rst_n`/`locked` fall 2 edges after the first low sample and `loss_cnt`=1. Release follows 10 edges after relock.
- No lock:
  - Macro defined: `pll_lock` held 0 → first `pll_rst` rises at edge 32 after reset, stays high 4 cycles, and repeats every 36 cycles. `retry_cnt` goes 1, 2, 3, 3.
  - Macro undefined: `pll_rst` stays 0 and `retry_cnt` stays 0.
- Saturation: 5 RUN→loss cycles → `loss_cnt`=3 and it stays 3.
- Async reset mid-RUN: pulse `rst_n` low between edges → `sys_rst_n`/`locked` go 0 before the next edge and `loss_cnt`=0. After reset, full re-qualification takes 10 edges.
